// File: rtl/delta_pkg.sv
// Shared widths, FSM state type and signed saturation for the serial delta unit.
package delta_pkg;

    localparam int SAT_XW = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_OUT
    } state_t;

    function automatic int calc_w(input int wc, input int wd);
        return wc + wd;
    endfunction

    function automatic int calc_wa(input int wc, input int wd, input int nn);
        return wc + wd + $clog2(nn);
    endfunction

    // Clamp a sign-extended value into the w-bit signed range.
    function automatic logic signed [SAT_XW-1:0] sat_signed(
        input logic signed [SAT_XW-1:0] x,
        input int                       w
    );
        logic signed [SAT_XW-1:0] hi;
        logic signed [SAT_XW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/delta_lane.sv
// One current-layer neuron: saturated weighted-delta accumulation with ReLU mask,
// or activation-minus-target in output mode. Result is registered on the last beat.
module delta_lane
    import delta_pkg::*;
#(
    parameter int W  = 8,
    parameter int WD = 4,
    parameter int WA = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [W-1:0]  i_act,
    input  logic [W-1:0]  i_aux,
    input  logic [W-1:0]  i_delta,
    input  logic          i_first,
    input  logic          i_beat,
    input  logic          i_last,
    input  logic          i_hidden,
    output logic [WA-1:0] o_result
);

    localparam int XW = WA - W;

    logic signed [2*W-1:0] w_aux_x;
    logic signed [2*W-1:0] w_delta_x;
    logic signed [2*W-1:0] w_prod;
    logic signed [2*W-1:0] w_shift;
    logic [W-1:0]          w_term;
    logic [W-1:0]          w_act_eff;
    logic [WA-1:0]         w_term_x;
    logic [WA-1:0]         w_sum;
    logic [WA-1:0]         w_act_x;
    logic [WA-1:0]         w_aux_ext;
    logic [WA-1:0]         w_diff;
    logic [WA-1:0]         w_result;

    logic [W-1:0]          r_act;
    logic [WA-1:0]         r_acc;
    logic [WA-1:0]         r_out;

    // Operands widened first so the 2W-bit product keeps its full signed value.
    assign w_aux_x   = {{W{i_aux[W-1]}}, i_aux};
    assign w_delta_x = {{W{i_delta[W-1]}}, i_delta};
    assign w_prod    = w_aux_x * w_delta_x;
    assign w_shift   = w_prod >>> WD;
    assign w_term    = W'(sat_signed({{(SAT_XW-2*W){w_shift[2*W-1]}}, w_shift}, W));
    assign w_term_x  = {{XW{w_term[W-1]}}, w_term};

    assign w_sum     = (i_first ? '0 : r_acc) + w_term_x;
    assign w_act_x   = {{XW{i_act[W-1]}}, i_act};
    assign w_aux_ext = {{XW{i_aux[W-1]}}, i_aux};
    assign w_diff    = w_act_x - w_aux_ext;

    // The mask uses the activation captured on the first beat, or the live one on that beat.
    assign w_act_eff = i_first ? i_act : r_act;
    assign w_result  = !i_hidden ? w_diff :
                       (!w_act_eff[W-1] && (w_act_eff != '0)) ? w_sum : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act <= '0;
            r_acc <= '0;
            r_out <= '0;
        end else begin
            if (i_first) r_act <= i_act;
            if (i_first || i_beat) r_acc <= w_sum;
            if (i_last) r_out <= w_result;
        end
    end

    assign o_result = r_out;

endmodule

// File: rtl/delta_serial.sv
// Time-multiplexed backprop delta unit: FSM, beat counter and stream handshakes
// around NC delta_lane instances.
module delta_serial
    import delta_pkg::*;
#(
    parameter  int NC = 4,
    parameter  int NN = 4,
    parameter  int WC = 4,
    parameter  int WD = 4,
    localparam int W  = calc_w(WC, WD),
    localparam int WA = calc_wa(WC, WD, NN)
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iValid_AS,
    output logic                  oReady_AS,
    input  logic                  iHidden_AS,
    input  logic [(2*NC+1)*W-1:0] iData_AS,
    output logic                  oValid_BS,
    input  logic                  iReady_BS,
    output logic [NC*WA-1:0]      oData_BS
);

    localparam int            KW     = $clog2(NN);
    localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic          r_hidden;
    logic          r_ready;
    logic          r_valid;

    logic          w_in_hs;
    logic          w_first;
    logic          w_beat;
    logic          w_last;
    logic          w_mode;

    assign w_in_hs = iValid_AS && r_ready;
    assign w_first = w_in_hs && (r_state == ST_IDLE);
    assign w_beat  = w_in_hs && (r_state == ST_ACCUM);
    assign w_last  = (w_first && !iHidden_AS) || (w_beat && (r_k == K_LAST));
    assign w_mode  = (r_state == ST_IDLE) ? iHidden_AS : r_hidden;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_hidden <= 1'b0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_first) begin
                    r_hidden <= iHidden_AS;
                    if (iHidden_AS) begin
                        r_k     <= KW'(1);
                        r_state <= ST_ACCUM;
                    end else begin
                        r_state <= ST_OUT;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                ST_ACCUM: if (w_beat) begin
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= ST_OUT;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_OUT: if (iReady_BS) begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign oReady_AS = r_ready;
    assign oValid_BS = r_valid;

    for (genvar j = 0; j < NC; j++) begin : g_lane
        delta_lane #(
            .W  (W),
            .WD (WD),
            .WA (WA)
        ) u_lane (
            .i_clk    (iCLK),
            .i_rst_n  (iRST),
            .i_act    (iData_AS[j*W +: W]),
            .i_aux    (iData_AS[(NC+j)*W +: W]),
            .i_delta  (iData_AS[2*NC*W +: W]),
            .i_first  (w_first),
            .i_beat   (w_beat),
            .i_last   (w_last),
            .i_hidden (w_mode),
            .o_result (oData_BS[j*WA +: WA])
        );
    end

endmodule

// File: tb/tb_delta_serial.sv
// Self-checking bench for delta_serial: directed vector table, reset-in-flight
// sequence and randomized transactions against an arithmetic reference model.
module tb_delta_serial;

    localparam int NC = 2;
    localparam int NN = 4;
    localparam int WC = 4;
    localparam int WD = 4;
    localparam int W  = 8;
    localparam int WA = 10;
    localparam int SAT_HI = (1 <<< (W - 1)) - 1;
    localparam int SAT_LO = -(1 <<< (W - 1));

    typedef struct packed {
        logic                          hidden;
        logic [NC-1:0][W-1:0]          act;
        logic [NN-1:0][NC-1:0][W-1:0]  aux;
        logic [NN-1:0][W-1:0]          dlt;
    } txn_t;

    typedef struct {
        string            name;
        txn_t             t;
        logic [NC*WA-1:0] exp;
        int               gap;
        int               bp;
    } vec_t;

    logic                  iCLK = 1'b0;
    logic                  iRST = 1'b0;
    logic                  iValid_AS = 1'b0;
    logic                  oReady_AS;
    logic                  iHidden_AS = 1'b0;
    logic [(2*NC+1)*W-1:0] iData_AS = '0;
    logic                  oValid_BS;
    logic                  iReady_BS = 1'b1;
    logic [NC*WA-1:0]      oData_BS;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    delta_serial #(
        .NC (NC),
        .NN (NN),
        .WC (WC),
        .WD (WD)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iValid_AS  (iValid_AS),
        .oReady_AS  (oReady_AS),
        .iHidden_AS (iHidden_AS),
        .iData_AS   (iData_AS),
        .oValid_BS  (oValid_BS),
        .iReady_BS  (iReady_BS),
        .oData_BS   (oData_BS)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: each term is floor(w*d / 2^WD) clamped to W bits, summed, then ReLU-masked.
    function automatic logic [NC*WA-1:0] model(input txn_t t);
        logic [NC*WA-1:0] r;
        int a, s, p;
        r = '0;
        for (int j = 0; j < NC; j++) begin
            a = int'($signed(t.act[j]));
            if (t.hidden) begin
                s = 0;
                for (int b = 0; b < NN; b++) begin
                    p = int'($signed(t.aux[b][j])) * int'($signed(t.dlt[b]));
                    p = p >>> WD;
                    if (p > SAT_HI) p = SAT_HI;
                    if (p < SAT_LO) p = SAT_LO;
                    s += p;
                end
                if (a <= 0) s = 0;
            end else begin
                s = a - int'($signed(t.aux[0][j]));
            end
            r[j*WA +: WA] = s[WA-1:0];
        end
        return r;
    endfunction

    function automatic txn_t mk_hid(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                    input logic [W-1:0] w, input logic [W-1:0] d);
        txn_t t;
        t = '0;
        t.hidden = 1'b1;
        t.act    = {a1, a0};
        for (int b = 0; b < NN; b++) begin
            t.dlt[b] = d;
            for (int j = 0; j < NC; j++) t.aux[b][j] = w;
        end
        return t;
    endfunction

    function automatic txn_t mk_out(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                    input logic [W-1:0] t0, input logic [W-1:0] t1);
        txn_t t;
        t = '0;
        t.hidden = 1'b0;
        t.act    = {a1, a0};
        t.aux[0] = {t1, t0};
        t.dlt[0] = 8'h5A;
        return t;
    endfunction

    // Starts and ends just after a rising edge. Fields ignored after beat 1 get junk.
    task automatic run_txn(input vec_t v);
        int               nb;
        logic [NC*WA-1:0] held;
        nb = v.t.hidden ? NN : 1;
        iReady_BS = (v.bp == 0);
        for (int b = 0; b < nb; b++) begin
            iValid_AS = 1'b0;
            repeat (v.gap) begin
                @(posedge iCLK);
                #1;
            end
            iValid_AS  = 1'b1;
            iHidden_AS = (b == 0) ? v.t.hidden : 1'($urandom_range(0, 1));
            iData_AS   = {v.t.dlt[b], v.t.aux[b], (b == 0) ? v.t.act : 16'($urandom)};
            @(negedge iCLK);
            check($sformatf("%s.in_ready[%0d]", v.name, b), 32'(oReady_AS), 32'd1);
            @(posedge iCLK);
            #1;
            iValid_AS = 1'b0;
        end
        @(negedge iCLK);
        check($sformatf("%s.valid", v.name), 32'(oValid_BS), 32'd1);
        check($sformatf("%s.data", v.name), 32'(oData_BS), 32'(v.exp));
        check($sformatf("%s.ready_busy", v.name), 32'(oReady_AS), 32'd0);
        held = oData_BS;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge iCLK);
            check($sformatf("%s.hold_valid[%0d]", v.name, i), 32'(oValid_BS), 32'd1);
            check($sformatf("%s.hold_data[%0d]", v.name, i), 32'(oData_BS), 32'(held));
            check($sformatf("%s.hold_ready[%0d]", v.name, i), 32'(oReady_AS), 32'd0);
        end
        iReady_BS = 1'b1;
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check($sformatf("%s.post_valid", v.name), 32'(oValid_BS), 32'd0);
        check($sformatf("%s.post_ready", v.name), 32'(oReady_AS), 32'd1);
        check($sformatf("%s.post_data", v.name), 32'(oData_BS), 32'(v.exp));
        @(posedge iCLK);
        #1;
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        vecs[0] = '{"out_basic", mk_out(8'd32, 8'hF8, 8'd16, 8'd0), {10'h3F8, 10'd16}, 0, 0};
        vecs[1] = '{"hid_mask", mk_hid(8'd16, 8'd0, 8'd16, 8'd16), {10'd0, 10'd64}, 0, 0};
        vecs[2] = '{"hid_sat", mk_hid(8'd1, 8'd1, 8'd127, 8'd127), {10'd508, 10'd508}, 0, 0};
        vecs[3] = '{"hid_floor", mk_hid(8'd16, 8'd16, 8'hFF, 8'd1), {10'h3FC, 10'h3FC}, 0, 0};
        vecs[4] = '{"out_edge", mk_out(8'h80, 8'h7F, 8'h7F, 8'h80), {10'h0FF, 10'h301}, 0, 0};
        vecs[5] = '{"hid_bp_gap", mk_hid(8'd16, 8'd0, 8'd16, 8'd16), {10'd0, 10'd64}, 2, 5};

        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset.valid", 32'(oValid_BS), 32'd0);
        check("reset.data", 32'(oData_BS), 32'd0);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("reset.ready", 32'(oReady_AS), 32'd1);
        @(posedge iCLK);
        #1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Leave a non-zero result on the outputs, then reset after two hidden beats.
        run_txn(vecs[3]);
        for (int b = 0; b < 2; b++) begin
            iValid_AS  = 1'b1;
            iHidden_AS = 1'b1;
            iData_AS   = {vecs[1].t.dlt[b], vecs[1].t.aux[b], vecs[1].t.act};
            @(posedge iCLK);
            #1;
            iValid_AS = 1'b0;
        end
        #2;
        iRST = 1'b0;
        #1;
        check("midrst.valid", 32'(oValid_BS), 32'd0);
        check("midrst.data", 32'(oData_BS), 32'd0);
        @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("midrst.ready", 32'(oReady_AS), 32'd1);
        @(posedge iCLK);
        #1;
        vecs[1].name = "after_rst";
        run_txn(vecs[1]);

        for (int n = 0; n < 24; n++) begin
            rv.name     = $sformatf("rand%0d", n);
            rv.t.hidden = 1'($urandom_range(0, 1));
            rv.t.act    = 16'($urandom);
            rv.t.aux    = {$urandom, $urandom};
            rv.t.dlt    = 32'($urandom);
            rv.exp      = model(rv.t);
            rv.gap      = int'($urandom_range(0, 2));
            rv.bp       = int'($urandom_range(0, 3));
            run_txn(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
